// File: rtl/fibonacci_index_finder.sv
// fibonacci_index_finder - iterative search for the largest Fibonacci number <= V and its index.
// Walks the sequence one term per cycle from F(2); reports index, value and exact-match flag.
module fibonacci_index_finder #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             begin_search,
  input  logic [WIDTH-1:0] value_in,
  output logic             busy,
  output logic             done,
  output logic             is_fib,
  output logic [IDX_W-1:0] index_out,
  output logic [WIDTH-1:0] floor_out
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] v_q;
  logic [WIDTH-1:0] cur_q;
  logic [WIDTH-1:0] prev_q;
  logic [IDX_W-1:0] idx_q;
  logic             is_fib_q;
  logic [IDX_W-1:0] index_q;
  logic [WIDTH-1:0] floor_q;

  // One extra bit so the step past the last representable term is visible as a carry.
  logic [WIDTH:0]   next_d;
  assign next_d = {1'b0, cur_q} + {1'b0, prev_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      v_q      <= '0;
      cur_q    <= '0;
      prev_q   <= '0;
      idx_q    <= '0;
      is_fib_q <= 1'b0;
      index_q  <= '0;
      floor_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (begin_search) begin
            if (value_in == '0) begin
              state_q  <= DONE;
              is_fib_q <= 1'b0;
              index_q  <= '0;
              floor_q  <= '0;
            end else if (value_in == WIDTH'(1)) begin
              state_q  <= DONE;
              is_fib_q <= 1'b1;
              index_q  <= IDX_W'(1);
              floor_q  <= WIDTH'(1);
            end else begin
              state_q <= SEARCH;
              v_q     <= value_in;
              cur_q   <= WIDTH'(1);
              prev_q  <= WIDTH'(1);
              idx_q   <= IDX_W'(2);
            end
          end
        end
        SEARCH: begin
          if (cur_q == v_q) begin
            state_q  <= DONE;
            is_fib_q <= 1'b1;
            index_q  <= idx_q;
            floor_q  <= cur_q;
          end else if (cur_q > v_q) begin
            state_q  <= DONE;
            is_fib_q <= 1'b0;
            index_q  <= idx_q - IDX_W'(1);
            floor_q  <= prev_q;
          end else if (next_d[WIDTH]) begin
            state_q  <= DONE;
            is_fib_q <= 1'b0;
            index_q  <= idx_q;
            floor_q  <= cur_q;
          end else begin
            prev_q <= cur_q;
            cur_q  <= next_d[WIDTH-1:0];
            idx_q  <= idx_q + IDX_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == SEARCH);
  assign done      = (state_q == DONE);
  assign is_fib    = is_fib_q;
  assign index_out = index_q;
  assign floor_out = floor_q;

endmodule

// File: tb/tb_fibonacci_index_finder.sv
// tb/tb_fibonacci_index_finder.sv - directed and random checks of fibonacci_index_finder against a table model.
module tb_fibonacci_index_finder;

  logic        clk = 1'b0;
  logic        reset;
  logic        begin_search;
  logic [15:0] value_in;
  logic        busy;
  logic        done;
  logic        is_fib;
  logic [4:0]  index_out;
  logic [15:0] floor_out;

  int n_assert = 0;
  int n_fail   = 0;
  int fib [0:26];

  fibonacci_index_finder #(.WIDTH(16), .IDX_W(5)) dut (
    .clk(clk), .reset(reset), .begin_search(begin_search), .value_in(value_in),
    .busy(busy), .done(done), .is_fib(is_fib), .index_out(index_out), .floor_out(floor_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: largest k with F(k) <= v; cycles are edges after the accept edge until done.
  task automatic model(input int v, output int e_fib, output int e_idx, output int e_floor, output int e_lat);
    int k;
    if (v == 0) begin
      e_fib = 0; e_idx = 0; e_floor = 0; e_lat = 0;
    end else if (v == 1) begin
      e_fib = 1; e_idx = 1; e_floor = 1; e_lat = 0;
    end else begin
      k = 2;
      while (fib[k+1] <= v) k++;
      e_fib   = (fib[k] == v) ? 1 : 0;
      e_idx   = k;
      e_floor = fib[k];
      if (e_fib == 1 || fib[k+1] > 65535) e_lat = k - 1;
      else e_lat = k;
    end
  endtask

  task automatic start(input logic [15:0] v);
    @(negedge clk);
    begin_search = 1'b1;
    value_in     = v;
    @(posedge clk); #1;
    begin_search = 1'b0;
    value_in     = 16'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_and_check(input string tag, input logic [15:0] v);
    int lat, e_fib, e_idx, e_floor, e_lat;
    model(int'(v), e_fib, e_idx, e_floor, e_lat);
    start(v);
    wait_done(lat);
    check({tag, ".done"},   32'(done),      32'd1);
    check({tag, ".busy"},   32'(busy),      32'd0);
    check({tag, ".is_fib"}, 32'(is_fib),    32'(e_fib));
    check({tag, ".index"},  32'(index_out), 32'(e_idx));
    check({tag, ".floor"},  32'(floor_out), 32'(e_floor));
    check({tag, ".lat"},    32'(lat),       32'(e_lat));
  endtask

  typedef struct {
    logic [15:0] v;
    int          f;
    int          idx;
    int          fl;
    int          lat;
  } vec_t;

  initial begin
    vec_t dir [6];
    int lat;
    int v;
    fib[0] = 0; fib[1] = 1;
    for (int i = 2; i <= 26; i++) fib[i] = fib[i-1] + fib[i-2];

    reset = 1'b1; begin_search = 1'b0; value_in = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst.busy",  32'(busy),      0);
    check("rst.done",  32'(done),      0);
    check("rst.isfib", 32'(is_fib),    0);
    check("rst.index", 32'(index_out), 0);
    check("rst.floor", 32'(floor_out), 0);
    reset = 1'b0;

    // Fixed vectors; cycles counted after the accept edge (V<=1 is done on that edge).
    dir[0] = '{16'd0,     0, 0,  0,     0};
    dir[1] = '{16'd1,     1, 1,  1,     0};
    dir[2] = '{16'd2,     1, 3,  2,     2};
    dir[3] = '{16'd46368, 1, 24, 46368, 23};
    dir[4] = '{16'd4,     0, 4,  3,     4};
    dir[5] = '{16'd65535, 0, 24, 46368, 23};
    foreach (dir[i]) begin
      start(dir[i].v);
      wait_done(lat);
      check("dir.done",  32'(done),      1);
      check("dir.isfib", 32'(is_fib),    32'(dir[i].f));
      check("dir.index", 32'(index_out), 32'(dir[i].idx));
      check("dir.floor", 32'(floor_out), 32'(dir[i].fl));
      check("dir.lat",   32'(lat),       32'(dir[i].lat));
    end

    repeat (5) @(posedge clk);
    #1;
    check("hold.done",  32'(done),      1);
    check("hold.index", 32'(index_out), 24);
    check("hold.floor", 32'(floor_out), 46368);

    // Reset during SEARCH aborts on the edge it is seen.
    start(16'd1000);
    @(posedge clk); @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("abort.busy",  32'(busy),      0);
    check("abort.done",  32'(done),      0);
    check("abort.isfib", 32'(is_fib),    0);
    check("abort.index", 32'(index_out), 0);
    check("abort.floor", 32'(floor_out), 0);
    reset = 1'b0;

    // Back-to-back accept from DONE.
    start(16'd21);
    wait_done(lat);
    check("b2b.done1",  32'(done),      1);
    check("b2b.isfib1", 32'(is_fib),    1);
    check("b2b.index1", 32'(index_out), 8);
    @(negedge clk); begin_search = 1'b1; value_in = 16'd22;
    @(posedge clk); #1;
    begin_search = 1'b0;
    check("b2b.drop", 32'(done), 0);
    wait_done(lat);
    check("b2b.isfib2", 32'(is_fib),    0);
    check("b2b.index2", 32'(index_out), 8);
    check("b2b.floor2", 32'(floor_out), 21);

    // Accept from DONE with V<=1 keeps done high.
    start(16'd0);
    check("b2b.small", 32'(done), 1);
    check("b2b.zero",  32'(index_out), 0);

    // begin_search mid-SEARCH is ignored.
    start(16'd1000);
    @(posedge clk); #1;
    @(negedge clk); begin_search = 1'b1; value_in = 16'd5;
    @(posedge clk); #1;
    begin_search = 1'b0;
    wait_done(lat);
    check("ign.isfib", 32'(is_fib),    0);
    check("ign.index", 32'(index_out), 16);
    check("ign.floor", 32'(floor_out), 987);
    check("ign.lat",   32'(lat) + 32'd2, 16);

    // Random sweep, half the picks clustered around sequence terms.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        v = fib[$urandom_range(24, 1)] + int'($urandom_range(2, 0)) - 1;
        if (v < 0) v = 0;
        if (v > 65535) v = 65535;
      end else begin
        v = int'($urandom_range(65535, 0));
      end
      run_and_check("rnd", 16'(v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
